// File: rtl/exec_issue_ctrl.sv
// Issue control for one execute slot: single-cycle ALU ops or one shared multi-cycle unit.
// All state moves on the falling clock edge; reset is asynchronous and active low.
module exec_issue_ctrl #(
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic       I_CLOCK,
  input  logic       I_RESET_N,
  input  logic       I_LOCK,
  input  logic       I_Valid,
  input  logic       I_IsMulti,
  input  logic [3:0] I_DestRegIdx,
  input  logic       I_OutReady,
  input  logic       I_Flush,
  output logic       O_Ready,
  output logic       O_DepStall,
  output logic       O_MulStart,
  output logic       O_MulAbort,
  output logic       O_OutValid,
  output logic       O_OutSel,
  output logic [3:0] O_DestRegIdx,
  output logic       O_PendingValid,
  output logic [3:0] O_PendingDest
);

  typedef enum logic [1:0] {StIdle, StMulti, StDone} state_e;

  localparam logic [3:0] CntLoad = 4'(MUL_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       out_valid_q, out_valid_d;
  logic       out_sel_q, out_sel_d;
  logic [3:0] dest_q, dest_d;
  logic       mul_start_q, mul_start_d;
  logic       mul_abort_q, mul_abort_d;
  logic       accept;

  assign O_Ready    = (state_q == StIdle) || ((state_q == StDone) && I_OutReady);
  assign O_DepStall = I_Valid && !O_Ready;
  assign accept     = I_Valid && O_Ready && !I_Flush;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_sel_d   = out_sel_q;
    dest_d      = dest_q;
    // Pulses are one cycle wide, including across frozen edges.
    mul_start_d = 1'b0;
    mul_abort_d = 1'b0;
    if (I_LOCK) begin
      if (I_Flush) begin
        state_d     = StIdle;
        cnt_d       = 4'd0;
        out_valid_d = 1'b0;
        mul_abort_d = (state_q == StMulti);
      end else if (accept) begin
        dest_d = I_DestRegIdx;
        if (I_IsMulti) begin
          state_d     = StMulti;
          cnt_d       = CntLoad;
          out_valid_d = 1'b0;
          out_sel_d   = 1'b1;
          mul_start_d = 1'b1;
        end else begin
          state_d     = StDone;
          out_valid_d = 1'b1;
          out_sel_d   = 1'b0;
        end
      end else begin
        unique case (state_q)
          StMulti: begin
            if (cnt_q != 4'd0) begin
              cnt_d = cnt_q - 4'd1;
            end else begin
              state_d     = StDone;
              out_valid_d = 1'b1;
              out_sel_d   = 1'b1;
            end
          end
          StDone: begin
            if (I_OutReady) begin
              state_d     = StIdle;
              out_valid_d = 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      out_valid_q <= 1'b0;
      out_sel_q   <= 1'b0;
      dest_q      <= 4'd0;
      mul_start_q <= 1'b0;
      mul_abort_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_sel_q   <= out_sel_d;
      dest_q      <= dest_d;
      mul_start_q <= mul_start_d;
      mul_abort_q <= mul_abort_d;
    end
  end

  assign O_MulStart     = mul_start_q;
  assign O_MulAbort     = mul_abort_q;
  assign O_OutValid     = out_valid_q;
  assign O_OutSel       = out_sel_q;
  assign O_DestRegIdx   = dest_q;
  assign O_PendingValid = (state_q != StIdle);
  assign O_PendingDest  = dest_q;

endmodule

// File: tb/tb_exec_issue_ctrl.sv
// Directed bench for exec_issue_ctrl; inputs change and outputs are sampled 1 time unit
// after each falling (active) edge.
module tb_exec_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       lock, valid, is_multi, out_ready, flush;
  logic [3:0] dest_in;
  logic       ready, dep_stall, mul_start, mul_abort, out_valid, out_sel, pend_valid;
  logic [3:0] dest_out, pend_dest;

  int checks = 0;
  int failures = 0;

  exec_issue_ctrl #(.MUL_CYCLES(4)) dut (
    .I_CLOCK        (clk),
    .I_RESET_N      (rst_n),
    .I_LOCK         (lock),
    .I_Valid        (valid),
    .I_IsMulti      (is_multi),
    .I_DestRegIdx   (dest_in),
    .I_OutReady     (out_ready),
    .I_Flush        (flush),
    .O_Ready        (ready),
    .O_DepStall     (dep_stall),
    .O_MulStart     (mul_start),
    .O_MulAbort     (mul_abort),
    .O_OutValid     (out_valid),
    .O_OutSel       (out_sel),
    .O_DestRegIdx   (dest_out),
    .O_PendingValid (pend_valid),
    .O_PendingDest  (pend_dest)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    check_eq("start_abort_excl", {31'd0, mul_start & mul_abort}, 32'd0);
  endtask

  task automatic check_out(input string tag, input logic v, input logic s, input logic [3:0] d);
    check_eq({tag, "_valid"}, {31'd0, out_valid}, {31'd0, v});
    check_eq({tag, "_sel"}, {31'd0, out_sel}, {31'd0, s});
    check_eq({tag, "_dest"}, {28'd0, dest_out}, {28'd0, d});
  endtask

  initial begin
    rst_n = 1'b0; lock = 1'b1; valid = 1'b0; is_multi = 1'b0;
    dest_in = 4'd0; out_ready = 1'b1; flush = 1'b0;
    #2;
    check_out("rst", 1'b0, 1'b0, 4'd0);
    check_eq("rst_start", {31'd0, mul_start}, 32'd0);
    check_eq("rst_pend", {31'd0, pend_valid}, 32'd0);
    check_eq("rst_ready", {31'd0, ready}, 32'd1);
    @(posedge clk);
    rst_n = 1'b1;

    // Single-cycle op
    valid = 1'b1; is_multi = 1'b0; dest_in = 4'd5;
    #1;
    check_eq("s_ready", {31'd0, ready}, 32'd1);
    check_eq("s_stall", {31'd0, dep_stall}, 32'd0);
    tick();
    check_out("s_done", 1'b1, 1'b0, 4'd5);
    check_eq("s_pend_v", {31'd0, pend_valid}, 32'd1);
    check_eq("s_pend_d", {28'd0, pend_dest}, 32'd5);
    valid = 1'b0;
    tick();
    check_eq("s_idle_v", {31'd0, out_valid}, 32'd0);
    check_eq("s_idle_p", {31'd0, pend_valid}, 32'd0);

    // Multi op with a waiting single op and backpressure in DONE
    valid = 1'b1; is_multi = 1'b1; dest_in = 4'd9; out_ready = 1'b0;
    tick();  // edge 0
    check_eq("m_start0", {31'd0, mul_start}, 32'd1);
    check_out("m_e0", 1'b0, 1'b1, 4'd9);
    is_multi = 1'b0; dest_in = 4'd3;
    #1;
    check_eq("m_ready", {31'd0, ready}, 32'd0);
    check_eq("m_stall", {31'd0, dep_stall}, 32'd1);
    tick();  // edge 1
    check_eq("m_start1", {31'd0, mul_start}, 32'd0);
    tick();
    tick();  // edge 3
    check_eq("m_e3_valid", {31'd0, out_valid}, 32'd0);
    tick();  // edge 4
    check_out("m_e4", 1'b1, 1'b1, 4'd9);
    check_eq("m_e4_stall", {31'd0, dep_stall}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("bp_hold", 1'b1, 1'b1, 4'd9);
      check_eq("bp_stall", {31'd0, dep_stall}, 32'd1);
    end
    out_ready = 1'b1;
    #1;
    check_eq("bp_ready", {31'd0, ready}, 32'd1);
    check_eq("bp_nostall", {31'd0, dep_stall}, 32'd0);
    tick();
    check_out("b2b", 1'b1, 1'b0, 4'd3);
    valid = 1'b0;
    tick();
    check_eq("b2b_idle", {31'd0, pend_valid}, 32'd0);

    // Flush at edge 2 of a multi op
    valid = 1'b1; is_multi = 1'b1; dest_in = 4'd7;
    tick();  // edge 0
    valid = 1'b0;
    tick();  // edge 1
    flush = 1'b1;
    tick();  // edge 2
    check_eq("f_abort", {31'd0, mul_abort}, 32'd1);
    check_eq("f_start", {31'd0, mul_start}, 32'd0);
    check_eq("f_valid", {31'd0, out_valid}, 32'd0);
    check_eq("f_idle", {31'd0, pend_valid}, 32'd0);
    flush = 1'b0;
    tick();
    check_eq("f_abort_end", {31'd0, mul_abort}, 32'd0);
    check_eq("f_valid2", {31'd0, out_valid}, 32'd0);

    // Flush in IDLE beats a presented op; no abort since not in MULTI
    valid = 1'b1; is_multi = 1'b0; dest_in = 4'd2; flush = 1'b1;
    tick();
    check_eq("fi_noacc", {31'd0, pend_valid}, 32'd0);
    check_eq("fi_noabort", {31'd0, mul_abort}, 32'd0);
    flush = 1'b0; valid = 1'b0;

    // Lock low for 2 edges right after accept
    valid = 1'b1; is_multi = 1'b1; dest_in = 4'd12;
    tick();  // edge 0
    valid = 1'b0; lock = 1'b0;
    tick();  // edge 1 frozen
    check_eq("l_start_drop", {31'd0, mul_start}, 32'd0);
    check_eq("l_pend", {31'd0, pend_valid}, 32'd1);
    tick();  // edge 2 frozen
    lock = 1'b1;
    tick();
    tick();
    tick();  // edge 5
    check_eq("l_e5_valid", {31'd0, out_valid}, 32'd0);
    tick();  // edge 6
    check_out("l_e6", 1'b1, 1'b1, 4'd12);
    tick();
    check_eq("l_idle", {31'd0, pend_valid}, 32'd0);

    // Async reset mid-MULTI between edges
    valid = 1'b1; is_multi = 1'b1; dest_in = 4'd10;
    tick();
    valid = 1'b0;
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    check_out("ar", 1'b0, 1'b0, 4'd0);
    check_eq("ar_pend", {31'd0, pend_valid}, 32'd0);
    check_eq("ar_abort", {31'd0, mul_abort}, 32'd0);
    @(negedge clk);
    #1;
    check_eq("ar_abort2", {31'd0, mul_abort}, 32'd0);
    @(posedge clk);
    rst_n = 1'b1;
    valid = 1'b1; is_multi = 1'b0; dest_in = 4'd6;
    tick();
    check_out("ar_first", 1'b1, 1'b0, 4'd6);
    valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exec_issue_ctrl.md
EXEC_ISSUE_CTRL -- requirements
Module: exec_issue_ctrl

Interface
REQ-001 The block SHALL have parameter MUL_CYCLES, default 4, legal range 2..16, giving the latency of the shared multi-cycle unit in enabled edges.
REQ-002 I_CLOCK  in  1  single clock; all state SHALL update on its negative edge.
REQ-003 I_RESET_N  in  1  asynchronous, active-low reset.
REQ-004 I_LOCK  in  1  pipeline enable; 0 freezes all state.
REQ-005 I_Valid  in  1  decode presents an op.
REQ-006 I_IsMulti  in  1  the presented op needs the shared multi-cycle unit.
REQ-007 I_DestRegIdx  in  4  destination register of the presented op.
REQ-008 I_OutReady  in  1  memory stage accepts the result.
REQ-009 I_Flush  in  1  kill any in-flight op.
REQ-010 O_Ready  out  1  combinational; an op can be accepted at the next edge.
REQ-011 O_DepStall  out  1  combinational; stall request to decode.
REQ-012 O_MulStart  out  1  one-cycle start pulse to the multi-cycle unit.
REQ-013 O_MulAbort  out  1  one-cycle abort pulse to the multi-cycle unit.
REQ-014 O_OutValid  out  1  result valid to the memory stage.
REQ-015 O_OutSel  out  1  result source: 0 = single-cycle ALU, 1 = multi-cycle unit.
REQ-016 O_DestRegIdx  out  4  destination of the held or in-flight op.
REQ-017 O_PendingValid / O_PendingDest  out  1 / 4  hazard info for decode.

Function
REQ-018 States SHALL be IDLE, MULTI and DONE, with a 4-bit down-counter CNT.
REQ-019 O_Ready SHALL equal (state==IDLE) OR (state==DONE AND I_OutReady).
REQ-020 O_DepStall SHALL equal I_Valid AND NOT O_Ready.
REQ-021 Accept SHALL occur at an edge with I_LOCK=1, I_Valid=1, O_Ready=1 and I_Flush=0.
REQ-022 Accept with I_IsMulti=0 SHALL transition to DONE with O_OutValid=1, O_OutSel=0, and O_DestRegIdx=I_DestRegIdx (latency 1 edge).
REQ-023 Accept with I_IsMulti=1 SHALL:
- transition to MULTI;
- load CNT=MUL_CYCLES-1;
- latch O_DestRegIdx;
- set O_MulStart=1 for exactly the following cycle.
REQ-024 In MULTI, each enabled edge with CNT>0 SHALL decrement CNT.
REQ-025 In MULTI, an enabled edge with CNT==0 SHALL transition to DONE with O_OutValid=1 and O_OutSel=1, giving a result MUL_CYCLES edges after accept.
REQ-026 In DONE, O_OutValid, O_OutSel and O_DestRegIdx SHALL hold until an enabled edge with I_OutReady=1.
REQ-027 At that edge, DONE SHALL either accept a new op (per REQ-022/023, back-to-back, no bubble) or go to IDLE with O_OutValid=0.
REQ-028 O_PendingValid SHALL equal (state!=IDLE).
REQ-029 O_PendingDest SHALL equal O_DestRegIdx.
REQ-030 I_Flush=1 at an enabled edge SHALL have priority over all else:
- state to IDLE, CNT=0, O_OutValid=0, O_MulStart=0;
- no accept at that edge;
- if the state was MULTI, O_MulAbort=1 for the following cycle only.
REQ-031 With I_LOCK=0, state, CNT and all registered outputs SHALL hold, except that O_MulStart and O_MulAbort SHALL be 0 after the edge; the combinational O_Ready and O_DepStall SHALL still follow REQ-019/020.
REQ-032 O_MulStart and O_MulAbort SHALL never both be 1 in the same cycle.

Reset
REQ-033 I_RESET_N=0 SHALL immediately, regardless of clock, force:
- state IDLE, CNT=0;
- O_OutValid=0, O_OutSel=0, O_DestRegIdx=0;
- O_MulStart=0, O_MulAbort=0.
REQ-034 Reset asserted mid-MULTI SHALL discard the op with no O_MulAbort pulse.
REQ-035 After release, the first accept SHALL be possible at the first enabled edge.

Verification
REQ-036 Single op: I_Valid=1, I_IsMulti=0, dest=5, I_OutReady=1 -> O_OutValid=1, O_OutSel=0, O_DestRegIdx=5 after one edge; IDLE after the next.
REQ-037 Multi op, MUL_CYCLES=4: accept at edge 0 -> O_MulStart high during cycle 0-1 only; O_DepStall=1 with I_Valid held; O_OutValid=1, O_OutSel=1 after edge 4.
REQ-038 Backpressure: I_OutReady=0 for 3 edges in DONE -> outputs stable, O_DepStall=1; I_OutReady=1 with a waiting op -> new op accepted at the same edge.
REQ-039 Flush at edge 2 of a multi op -> O_MulAbort pulse 1 cycle, O_OutValid stays 0, IDLE.
REQ-040 I_LOCK=0 for 2 edges mid-MULTI -> CNT frozen; result arrives 2 edges late (edge 6).
REQ-041 Async reset mid-MULTI between clock edges -> outputs 0 immediately, no abort pulse, accept works at the first edge after release.
